multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port Clear, input, 1, synchronous active-high reset, sampled on rising Clk.
REQ-003 SHALL have port Run, input, 1, permission to start a new instruction; sampled only in FETCH.
REQ-004 SHALL have port Op, input, 2, opcode from the instruction register: 00 R-type, 01 lw, 10 sw, 11 beq.
REQ-005 SHALL have port Zero, input, 1, ALU zero flag.
REQ-006 SHALL have port MemReady, input, 1, memory completion for the current MemRead/MemWrite request.
REQ-007 SHALL have outputs PCWrite, IorD, IRWrite, MemRead, MemWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, PCSource, each 1 bit, standard multicycle datapath controls.
REQ-008 SHALL have outputs ALUSrcB, 2 (00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm), and ALUOp, 2 (00 add, 01 sub, 10 funct).
REQ-009 SHALL have outputs InstrDone, 1, one-cycle retire pulse, and InstrCount, 16, retired-instruction count.

Function
REQ-010 SHALL be a Moore FSM, 4-bit state: FETCH, DECODE, EXEC_R, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH; control outputs decoded from state (plus Run/MemReady/Zero where stated).
REQ-011 Unlisted controls SHALL be 0 in every state.
REQ-012 FETCH, Run=0: all controls 0, stay in FETCH (idle).
REQ-013 FETCH, Run=1: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0; IRWrite=PCWrite=MemReady; MemReady=1 -> DECODE, else stay.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; Op 00 -> EXEC_R, 01/10 -> MEM_ADDR, 11 -> BRANCH.
REQ-015 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB. R_WB: RegDst=1, RegWrite=1, MemtoReg=0 -> FETCH.
REQ-016 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Op=01 -> MEM_RD, else MEM_WR.
REQ-017 MEM_RD: MemRead=1, IorD=1; MemReady=1 -> MEM_WB, else stay. MEM_WB: RegDst=0, RegWrite=1, MemtoReg=1 -> FETCH.
REQ-018 MEM_WR: MemWrite=1, IorD=1; MemReady=1 -> FETCH, else stay.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=Zero -> FETCH.
REQ-020 MemRead/MemWrite SHALL stay asserted, unchanged, until MemReady; MemReady outside a request state SHALL be ignored.
REQ-021 Cycle counts with MemReady always 1: R-type 4, lw 5, sw 4, beq 3; each wait cycle adds one.
REQ-022 InstrDone SHALL be registered, high the cycle after leaving R_WB, MEM_WB, MEM_WR (with MemReady) or BRANCH.
REQ-023 InstrCount SHALL increment by 1 per InstrDone, wrapping 0xFFFF -> 0x0000.
REQ-024 Run deassertion mid-instruction SHALL NOT abort it; it only blocks the next FETCH.

Reset
REQ-025 Clear=1 at a rising edge SHALL force FETCH, InstrDone=0, InstrCount=0, overriding every other input, including mid-instruction and mid-wait.
REQ-026 During and after Clear, outputs SHALL reflect FETCH (all 0 if Run=0); no write strobe may assert in the cycle after Clear.

Structure
REQ-027 A shared package SHALL hold the state encoding, Op codes (OP_R, OP_LW, OP_SW, OP_BEQ), ALUOp and ALUSrcB constants.
REQ-028 Single module; state register, next-state logic, output decode and retire counter in one file, no sub-modules.

Verification
REQ-029 Clear, Run=1, Op=00, MemReady=1 -> FETCH,DECODE,EXEC_R,R_WB; RegWrite=1/RegDst=1 in cycle 4; InstrDone next; InstrCount=1.
REQ-030 Op=01, MemReady low 3 cycles in MEM_RD -> MemRead,IorD held 4 cycles, lw total 8 cycles, MemtoReg=1 in MEM_WB.
REQ-031 Op=11, Zero=1 then Zero=0 -> PCWrite=1,PCSource=1 in BRANCH first, PCWrite=0 second; 3 cycles each.
REQ-032 Op=10 -> MemWrite=1 exactly 1 cycle with MemReady=1, RegWrite never asserted.
REQ-033 Clear asserted in MEM_WR while MemReady=0 -> next state FETCH, MemWrite=0, InstrCount=0.
REQ-034 Preload 65535 retires (or force) -> next InstrDone gives InstrCount=0x0000; Run=0 in FETCH -> all controls 0, counter frozen.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle datapath controller: state codes,
// opcodes, ALU operation and ALU B-source selectors.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8
    } state_t;

    localparam logic [1:0] OP_R   = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    // An instruction retires on the edge that leaves its final state.
    function automatic logic is_retire(input state_t s, input logic mem_ready);
        return (s == S_R_WB) || (s == S_MEM_WB) || (s == S_BRANCH) ||
               ((s == S_MEM_WR) && mem_ready);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath, with a registered
// retire pulse and a wrapping retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        Clk,
    input  logic        Clear,
    input  logic        Run,
    input  logic [1:0]  Op,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        InstrDone,
    output logic [15:0] InstrCount
);

    state_t state;
    state_t next_state;

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state      <= S_FETCH;
            InstrDone  <= 1'b0;
            InstrCount <= 16'h0000;
        end else begin
            state     <= next_state;
            InstrDone <= is_retire(state, MemReady);
            if (is_retire(state, MemReady))
                InstrCount <= InstrCount + 16'h0001;
        end
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        PCSource   = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                // Run is only a gate for starting; idle FETCH drives nothing.
                if (Run) begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                    if (MemReady)
                        next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_SHIMM;
                case (Op)
                    OP_R:    next_state = S_EXEC_R;
                    OP_BEQ:  next_state = S_BRANCH;
                    default: next_state = S_MEM_ADDR;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_FUNCT;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                next_state = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady)
                    next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady)
                    next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_SUB;
                PCSource   = 1'b1;
                PCWrite    = Zero;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: each row is one clock cycle of
// inputs with the controls, retire pulse and count expected in that cycle.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic        Clk = 1'b0;
    logic        Clear, Run, Zero, MemReady;
    logic [1:0]  Op;
    logic        PCWrite, IorD, IRWrite, MemRead, MemWrite, RegDst, RegWrite;
    logic        MemtoReg, ALUSrcA, PCSource, InstrDone;
    logic [1:0]  ALUSrcB, ALUOp;
    logic [15:0] InstrCount;

    always #5 Clk = ~Clk;

    multicycle_control dut (
        .Clk(Clk), .Clear(Clear), .Run(Run), .Op(Op), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .InstrDone(InstrDone), .InstrCount(InstrCount)
    );

    // {PCWrite,IorD,IRWrite,MemRead,MemWrite,RegDst,RegWrite,MemtoReg,
    //  ALUSrcA,PCSource,ALUSrcB[1:0],ALUOp[1:0]}
    localparam logic [13:0] C_IDLE  = 14'b00000000000000;
    localparam logic [13:0] C_FRDY  = 14'b10110000000100;
    localparam logic [13:0] C_FWAIT = 14'b00010000000100;
    localparam logic [13:0] C_DEC   = 14'b00000000001100;
    localparam logic [13:0] C_EXR   = 14'b00000000100010;
    localparam logic [13:0] C_RWB   = 14'b00000110000000;
    localparam logic [13:0] C_MADDR = 14'b00000000101000;
    localparam logic [13:0] C_MRD   = 14'b01010000000000;
    localparam logic [13:0] C_MWB   = 14'b00000011000000;
    localparam logic [13:0] C_MWR   = 14'b01001000000000;
    localparam logic [13:0] C_BRZ   = 14'b10000000110001;
    localparam logic [13:0] C_BRNZ  = 14'b00000000110001;

    typedef struct {
        logic        clear;
        logic        run;
        logic [1:0]  op;
        logic        zero;
        logic        mr;
        logic [13:0] ctl;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic c, input logic r, input logic [1:0] o,
                                input logic z, input logic m, input logic [13:0] ctl,
                                input logic d, input logic [15:0] n);
        vec_t v;
        v.clear = c; v.run = r; v.op = o; v.zero = z; v.mr = m;
        v.ctl = ctl; v.done = d; v.cnt = n;
        return v;
    endfunction

    function automatic logic [13:0] act_ctl();
        return {PCWrite, IorD, IRWrite, MemRead, MemWrite, RegDst, RegWrite,
                MemtoReg, ALUSrcA, PCSource, ALUSrcB, ALUOp};
    endfunction

    task automatic check(input string nm, input int id, input logic [15:0] got,
                         input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", nm, id, got, want);
    endtask

    task automatic step(input vec_t v, input int id);
        vec_t e;
        @(negedge Clk);
        Clear = v.clear; Run = v.run; Op = v.op; Zero = v.zero; MemReady = v.mr;
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        check("ctl",  id, {2'b00, act_ctl()}, {2'b00, e.ctl});
        check("done", id, {15'd0, InstrDone}, {15'd0, e.done});
        check("cnt",  id, InstrCount, e.cnt);
    endtask

    initial begin
        Clear = 1'b1; Run = 1'b0; Op = OP_R; Zero = 1'b0; MemReady = 1'b0;
        repeat (2) @(posedge Clk);

        // reset state, then idle
        tbl.push_back(mk(1, 0, OP_R,   0, 0, C_IDLE,  0, 0));
        tbl.push_back(mk(0, 0, OP_R,   0, 1, C_IDLE,  0, 0));
        // R-type: 4 cycles
        tbl.push_back(mk(0, 1, OP_R,   0, 1, C_FRDY,  0, 0));
        tbl.push_back(mk(0, 1, OP_R,   0, 1, C_DEC,   0, 0));
        tbl.push_back(mk(0, 1, OP_R,   0, 1, C_EXR,   0, 0));
        tbl.push_back(mk(0, 1, OP_R,   0, 1, C_RWB,   0, 0));
        tbl.push_back(mk(0, 0, OP_R,   0, 1, C_IDLE,  1, 1));
        tbl.push_back(mk(0, 0, OP_R,   0, 1, C_IDLE,  0, 1));
        // lw with three wait cycles in MEM_RD; MemReady low elsewhere is ignored
        tbl.push_back(mk(0, 1, OP_LW,  0, 1, C_FRDY,  0, 1));
        tbl.push_back(mk(0, 1, OP_LW,  0, 0, C_DEC,   0, 1));
        tbl.push_back(mk(0, 1, OP_LW,  0, 0, C_MADDR, 0, 1));
        tbl.push_back(mk(0, 1, OP_LW,  0, 0, C_MRD,   0, 1));
        tbl.push_back(mk(0, 1, OP_LW,  0, 0, C_MRD,   0, 1));
        tbl.push_back(mk(0, 1, OP_LW,  0, 0, C_MRD,   0, 1));
        tbl.push_back(mk(0, 1, OP_LW,  0, 1, C_MRD,   0, 1));
        tbl.push_back(mk(0, 0, OP_LW,  0, 1, C_MWB,   0, 1));
        tbl.push_back(mk(0, 0, OP_LW,  0, 1, C_IDLE,  1, 2));
        // sw with one fetch wait; Run drops mid-instruction
        tbl.push_back(mk(0, 1, OP_SW,  0, 0, C_FWAIT, 0, 2));
        tbl.push_back(mk(0, 1, OP_SW,  0, 1, C_FRDY,  0, 2));
        tbl.push_back(mk(0, 0, OP_SW,  0, 1, C_DEC,   0, 2));
        tbl.push_back(mk(0, 0, OP_SW,  0, 1, C_MADDR, 0, 2));
        tbl.push_back(mk(0, 0, OP_SW,  0, 1, C_MWR,   0, 2));
        tbl.push_back(mk(0, 0, OP_SW,  0, 1, C_IDLE,  1, 3));
        // beq taken, then not taken
        tbl.push_back(mk(0, 1, OP_BEQ, 1, 1, C_FRDY,  0, 3));
        tbl.push_back(mk(0, 1, OP_BEQ, 1, 1, C_DEC,   0, 3));
        tbl.push_back(mk(0, 1, OP_BEQ, 1, 1, C_BRZ,   0, 3));
        tbl.push_back(mk(0, 1, OP_BEQ, 0, 1, C_FRDY,  1, 4));
        tbl.push_back(mk(0, 1, OP_BEQ, 0, 1, C_DEC,   0, 4));
        tbl.push_back(mk(0, 1, OP_BEQ, 0, 1, C_BRNZ,  0, 4));
        tbl.push_back(mk(0, 0, OP_BEQ, 0, 1, C_IDLE,  1, 5));
        // Clear while sw waits in MEM_WR
        tbl.push_back(mk(0, 1, OP_SW,  0, 1, C_FRDY,  0, 5));
        tbl.push_back(mk(0, 1, OP_SW,  0, 1, C_DEC,   0, 5));
        tbl.push_back(mk(0, 1, OP_SW,  0, 1, C_MADDR, 0, 5));
        tbl.push_back(mk(1, 1, OP_SW,  0, 0, C_MWR,   0, 5));
        tbl.push_back(mk(0, 1, OP_SW,  0, 0, C_FWAIT, 0, 0));
        tbl.push_back(mk(0, 0, OP_SW,  0, 0, C_IDLE,  0, 0));

        foreach (tbl[i]) step(tbl[i], i);

        // Clear while lw waits in MEM_RD, with MemReady arriving the same edge
        step(mk(0, 1, OP_R,  0, 1, C_FRDY,  0, 0), 100);
        step(mk(0, 1, OP_R,  0, 1, C_DEC,   0, 0), 101);
        step(mk(0, 1, OP_R,  0, 1, C_EXR,   0, 0), 102);
        step(mk(0, 1, OP_R,  0, 1, C_RWB,   0, 0), 103);
        step(mk(0, 1, OP_LW, 0, 1, C_FRDY,  1, 1), 104);
        step(mk(0, 1, OP_LW, 0, 1, C_DEC,   0, 1), 105);
        step(mk(0, 1, OP_LW, 0, 1, C_MADDR, 0, 1), 106);
        step(mk(0, 1, OP_LW, 0, 0, C_MRD,   0, 1), 107);
        step(mk(1, 1, OP_LW, 0, 1, C_MRD,   0, 1), 108);
        step(mk(0, 0, OP_LW, 0, 1, C_IDLE,  0, 0), 109);

        // counter wrap: preload the count, retire one beq
        force dut.InstrCount = 16'hFFFF;
        #2;
        release dut.InstrCount;
        step(mk(0, 1, OP_BEQ, 1, 1, C_FRDY, 0, 16'hFFFF), 200);
        step(mk(0, 1, OP_BEQ, 1, 1, C_DEC,  0, 16'hFFFF), 201);
        step(mk(0, 1, OP_BEQ, 1, 1, C_BRZ,  0, 16'hFFFF), 202);
        step(mk(0, 0, OP_BEQ, 1, 1, C_IDLE, 1, 16'h0000), 203);
        step(mk(0, 0, OP_BEQ, 1, 1, C_IDLE, 0, 16'h0000), 204);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
